// File: rtl/rv32_rf_pkg.sv
// rv32_rf_pkg: shared state type and default constants for the rv32_rf_sb register file
package rv32_rf_pkg;
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int NUM_RD_D = 2;
  localparam logic [XLEN_D-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rv32_rf_rdport.sv
// rv32_rf_rdport: one combinational read port with x0 masking; RV32_RF_BYPASS_EN adds writeback forwarding
module rv32_rf_rdport
  import rv32_rf_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  localparam int AW = $clog2(NREG)
) (
  input  logic            i_run,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_rf [NREG],
  input  logic [NREG-1:0] i_sb,
  input  logic [NREG-1:0] i_sb_nxt,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_dat,
  output logic            o_busy
);
`ifdef RV32_RF_BYPASS_EN
  logic w_hit;
  assign w_hit  = i_we && i_wa == i_addr;
  assign o_dat  = (!i_run || i_addr == '0) ? XLEN'(REG_ZERO) : w_hit ? i_wd : i_rf[i_addr];
  assign o_busy = !i_run || (w_hit ? i_sb_nxt[i_addr] : i_sb[i_addr]);
`else
  logic w_unused;
  assign w_unused = ^{i_we, i_wa, i_wd, i_sb_nxt};
  assign o_dat    = (!i_run || i_addr == '0) ? XLEN'(REG_ZERO) : i_rf[i_addr];
  assign o_busy   = !i_run || i_sb[i_addr];
`endif
endmodule

// File: rtl/rv32_rf_sb.sv
// rv32_rf_sb: parametrised RV32 register file with post-reset clear and pending-write scoreboard (option: RV32_RF_BYPASS_EN)
module rv32_rf_sb
  import rv32_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREG   = NREG_D,
  parameter int NUM_RD = NUM_RD_D,
  localparam int AW = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rf_ready,
  input  logic                   c_rf_write,
  input  logic [AW-1:0]          rd_addr,
  input  logic [XLEN-1:0]        rd_dati,
  input  logic                   c_rf_resv,
  input  logic [AW-1:0]          resv_addr,
  output logic                   resv_busy,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_dato,
  output logic [NUM_RD-1:0]      rs_busy
);
  rf_state_e       r_state, w_state_nxt;
  logic [AW-1:0]   r_clr_ptr, w_clr_ptr_nxt;
  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_sb, w_sb_nxt;
  logic            w_run, w_we, w_resv;

  assign w_run    = r_state == RF_RUN;
  assign w_we     = w_run && c_rf_write && rd_addr != '0;
  assign w_resv   = w_run && c_rf_resv && resv_addr != '0;
  assign rf_ready = w_run;

  // Clear FSM state and sweep pointer; x0 is never stored so the sweep starts at 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= AW'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end

  // Advance the sweep while clearing; enter RUN after the last register is zeroed
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (!w_run) begin
      w_clr_ptr_nxt = r_clr_ptr + 1'b1;
      w_state_nxt   = (r_clr_ptr == AW'(NREG - 1)) ? RF_RUN : RF_CLEAR;
    end
  end

  // Scoreboard update: writeback releases, reserve sets, reserve applied last so it wins
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_we) w_sb_nxt[rd_addr] = 1'b0;
    if (w_resv) w_sb_nxt[resv_addr] = 1'b1;
  end

  // Scoreboard register, cleared by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sb <= '0;
    else r_sb <= w_sb_nxt;

  // Register array: zeroed by the clear sweep, then written by writeback
  always_ff @(posedge clk)
    if (!w_run) r_rf[r_clr_ptr] <= XLEN'(REG_ZERO);
    else if (w_we) r_rf[rd_addr] <= rd_dati;

`ifdef RV32_RF_BYPASS_EN
  assign resv_busy = !w_run || ((w_we && rd_addr == resv_addr) ? w_sb_nxt[resv_addr] : r_sb[resv_addr]);
`else
  assign resv_busy = !w_run || r_sb[resv_addr];
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rv32_rf_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd (
      .i_run    (w_run),
      .i_addr   (rs_addr[i*AW +: AW]),
      .i_rf     (r_rf),
      .i_sb     (r_sb),
      .i_sb_nxt (w_sb_nxt),
      .i_we     (w_we),
      .i_wa     (rd_addr),
      .i_wd     (rd_dati),
      .o_dat    (rs_dato[i*XLEN +: XLEN]),
      .o_busy   (rs_busy[i])
    );
  end
endmodule

// File: tb/tb_rv32_rf_sb.sv
// tb_rv32_rf_sb: scoreboard bench for rv32_rf_sb (default 32x32x2 and RV32E 16-reg 3-port builds)
module tb_rv32_rf_sb;
`ifdef RV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_rf_write = 1'b0, c_rf_resv = 1'b0;
  logic [4:0]  rd_addr = '0, resv_addr = '0;
  logic [31:0] rd_dati = '0;
  logic [9:0]  rs_addr = '0;
  logic        rf_ready, resv_busy;
  logic [63:0] rs_dato;
  logic [1:0]  rs_busy;
  logic        w16 = 1'b0;
  logic [3:0]  a16 = '0;
  logic [31:0] d16 = '0;
  logic [11:0] rs16 = '0;
  logic        ready16, resvb16;
  logic [95:0] dato16;
  logic [2:0]  busy16;

  always #5 clk = ~clk;

  rv32_rf_sb dut (
    .clk(clk), .rst(rst), .rf_ready(rf_ready), .c_rf_write(c_rf_write), .rd_addr(rd_addr),
    .rd_dati(rd_dati), .c_rf_resv(c_rf_resv), .resv_addr(resv_addr), .resv_busy(resv_busy),
    .rs_addr(rs_addr), .rs_dato(rs_dato), .rs_busy(rs_busy)
  );

  rv32_rf_sb #(.NREG(16), .NUM_RD(3)) dut16 (
    .clk(clk), .rst(rst), .rf_ready(ready16), .c_rf_write(w16), .rd_addr(a16),
    .rd_dati(d16), .c_rf_resv(1'b0), .resv_addr(4'd0), .resv_busy(resvb16),
    .rs_addr(rs16), .rs_dato(dato16), .rs_busy(busy16)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;
  chk_t q[$];
  chk_t m_e;
  int n_chk = 0, n_fail = 0;

  function automatic logic [31:0] obs(chk_t e);
    case (e.sel)
      0: return {31'b0, rf_ready};
      1: return rs_dato[31:0];
      2: return rs_dato[63:32];
      3: return {30'b0, rs_busy};
      4: return {31'b0, resv_busy};
      5: return dato16[31:0];
      6: return dato16[63:32];
      7: return dato16[95:64];
      8: return {31'b0, ready16};
      default: return e.act;
    endcase
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      m_e = q.pop_front();
      n_chk++;
      if (obs(m_e) !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", m_e.name, obs(m_e), m_e.exp);
      end
    end

  task automatic chk(input string n, input int sel, input logic [31:0] act, input logic [31:0] exp);
    q.push_back('{n, sel, act, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure();
    int n32 = -1, n16 = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 2) begin
        chk("clear_busy", 3, 0, 32'h3);
        chk("clear_dato", 1, 0, 32'h0);
        chk("clear_resv_busy", 4, 0, 32'h1);
      end
      if (k == 5) begin
        c_rf_write = 1'b1; rd_addr = 5'd5; rd_dati = 32'hFFFF_FFFF;
        c_rf_resv = 1'b1; resv_addr = 5'd6;
      end
      if (k == 6) begin
        c_rf_write = 1'b0; c_rf_resv = 1'b0;
      end
      step();
      if (ready16 && n16 < 0) n16 = k;
      if (rf_ready) begin
        n32 = k;
        break;
      end
    end
    chk("ready_lat32", 9, n32, 32'd31);
    chk("ready_lat16", 9, n16, 32'd15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_ready", 0, 0, 32'h0);
    chk("rst_busy", 3, 0, 32'h3);
    chk("rst_resv_busy", 4, 0, 32'h1);
    chk("rst_dato", 1, 0, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure();
    chk("ready_run", 0, 0, 32'h1);
    for (int r = 1; r < 32; r++) begin
      rs_addr = {5'(r), 5'(r)};
      chk($sformatf("sweep_x%0d", r), 1, 0, 32'h0);
      chk($sformatf("sweep_busy_x%0d", r), 3, 0, 32'h0);
      step();
    end
    resv_addr = 5'd6;
    chk("clear_resv_ignored", 4, 0, 32'h0);
    step();
    c_rf_write = 1'b1; rd_addr = 5'd5; rd_dati = 32'hDEAD_BEEF;
    step();
    c_rf_write = 1'b0; rs_addr = {5'd5, 5'd0};
    chk("x5_read_p1", 2, 0, 32'hDEAD_BEEF);
    step();
    c_rf_write = 1'b1; rd_addr = 5'd0; rd_dati = 32'h1234;
    step();
    c_rf_write = 1'b0;
    chk("x0_read", 1, 0, 32'h0);
    chk("x0_busy", 3, 0, 32'h0);
    step();
    c_rf_write = 1'b1; rd_addr = 5'd7; rd_dati = 32'hA5A5_A5A5; rs_addr = {5'd5, 5'd7};
    chk("x7_same_cycle", 1, 0, BYP ? 32'hA5A5_A5A5 : 32'h0);
    step();
    c_rf_write = 1'b0;
    chk("x7_next_cycle", 1, 0, 32'hA5A5_A5A5);
    step();
    c_rf_resv = 1'b1; resv_addr = 5'd9; rs_addr = {5'd5, 5'd9};
    chk("x9_resv_pre", 4, 0, 32'h0);
    step();
    c_rf_resv = 1'b0;
    chk("x9_rs_busy", 3, 0, 32'h1);
    chk("x9_resv_busy", 4, 0, 32'h1);
    step();
    c_rf_write = 1'b1; rd_addr = 5'd9; rd_dati = 32'h42;
    chk("x9_wb_busy_same", 3, 0, BYP ? 32'h0 : 32'h1);
    chk("x9_wb_dato_same", 1, 0, BYP ? 32'h42 : 32'h0);
    chk("x9_wb_resv_same", 4, 0, BYP ? 32'h0 : 32'h1);
    step();
    c_rf_write = 1'b0;
    chk("x9_released", 3, 0, 32'h0);
    chk("x9_resv_released", 4, 0, 32'h0);
    chk("x9_data", 1, 0, 32'h42);
    step();
    c_rf_write = 1'b1; c_rf_resv = 1'b1; rd_dati = 32'h77;
    chk("x9_wr_resv_same", 3, 0, BYP ? 32'h1 : 32'h0);
    step();
    c_rf_write = 1'b0; c_rf_resv = 1'b0;
    chk("x9_wr_resv_busy", 3, 0, 32'h1);
    chk("x9_wr_resv_data", 1, 0, 32'h77);
    step();
    c_rf_resv = 1'b1; resv_addr = 5'd3;
    step();
    c_rf_resv = 1'b0; rs_addr = {5'd5, 5'd3};
    chk("x3_reserved", 3, 0, 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("run_rst_ready", 0, 0, 32'h0);
    chk("run_rst_busy", 3, 0, 32'h3);
    measure();
    rs_addr = {5'd9, 5'd3};
    chk("x3_after_rst_busy", 3, 0, 32'h0);
    chk("x3_after_rst_resv", 4, 0, 32'h0);
    chk("x3_after_rst_data", 1, 0, 32'h0);
    chk("x9_after_rst_data", 2, 0, 32'h0);
    step();
    chk("r16_ready", 8, 0, 32'h1);
    w16 = 1'b1; a16 = 4'd3; d16 = 32'h11;
    step();
    a16 = 4'd7; d16 = 32'h22;
    step();
    a16 = 4'd15; d16 = 32'h33;
    step();
    w16 = 1'b0; rs16 = {4'd15, 4'd7, 4'd3};
    chk("r16_p0", 5, 0, 32'h11);
    chk("r16_p1", 6, 0, 32'h22);
    chk("r16_p2", 7, 0, 32'h33);
    step();
    rs16 = {4'd0, 4'd3, 4'd7};
    chk("r16_p0b", 5, 0, 32'h22);
    chk("r16_p1b", 6, 0, 32'h11);
    chk("r16_p2_x0", 7, 0, 32'h0);
    #1;
    n_chk++;
    if (dato16[63:32] !== 32'h11) begin
      n_fail++;
      $display("FAIL r16_p1b_direct: got %h expected %h", dato16[63:32], 32'h11);
    end
    n_chk++;
    if (dato16[95:64] !== 32'h0) begin
      n_fail++;
      $display("FAIL r16_p2_x0_direct: got %h expected %h", dato16[95:64], 32'h0);
    end
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_rf_sb.md
Name: rv32_rf_sb

Overview:
- Parametrised integer register file for the RV32 single-issue cores, successor to the fixed 2-read/1-write 32x32 RF.
- Adds:
  - configurable width, depth and read-port count;
  - a hardware clear sequence after reset;
  - a one-bit-per-register pending-write scoreboard for multicycle producers (load, mul/div).
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
- XLEN, 32, data width per register.
- NREG, 32, register count; 16 gives RV32E; must be a power of two, at least 2.
- NUM_RD, 2, number of combinational read ports (1..4).
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rf_ready  out  1  1 once the clear sequence has completed.
- c_rf_write  in  1  writeback strobe; writes and releases the scoreboard entry.
- rd_addr  in  AW  writeback address.
- rd_dati  in  XLEN  writeback data.
- c_rf_resv  in  1  reserve strobe from issue: marks rd pending.
- resv_addr  in  AW  register to reserve.
- resv_busy  out  1  scoreboard bit of resv_addr, combinational.
- rs_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_dato  out  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy  out  NUM_RD  per-port pending flag.

Behaviour:
- FSM states: CLEAR, RUN.
- While rst is high:
  - state=CLEAR, clr_ptr=1, scoreboard all 0, rf_ready=0.
  - Array contents are undefined.
- CLEAR:
  - Each cycle writes 0 to rf[clr_ptr] and increments clr_ptr.
  - After rf[NREG-1] is written, the next cycle is RUN with rf_ready=1.
  - Duration is NREG-1 cycles after rst deassertion: 31 for the default, 15 for RV32E.
  - During CLEAR: c_rf_write and c_rf_resv are ignored, rs_dato=0, rs_busy all 1, resv_busy=1.
- rst asserted mid-CLEAR or mid-RUN: immediate return to CLEAR, the sequence restarts, and the scoreboard is cleared.
- RUN write: if c_rf_write and rd_addr!=0, rf[rd_addr]<=rd_dati and sb[rd_addr]<=0. Writes to x0 are discarded.
- RUN reserve: if c_rf_resv and resv_addr!=0, sb[resv_addr]<=1.
- Same cycle, same nonzero address, write and reserve both asserted: reserve wins, so sb ends at 1 and the data is still written.
- Reserving an already-pending register leaves sb=1. Issue logic must check resv_busy first; the RF does not detect this.
- Reads are combinational:
  - rs_dato[i] = 0 if rs_addr[i]==0, else rf[rs_addr[i]].
  - rs_busy[i] = sb[rs_addr[i]], which is always 0 for x0.
- Reads return pre-edge array contents: a same-cycle write is visible next cycle, unless the optional feature below is compiled in.
- All outputs are driven in every state. No read latency; write latency is 1 cycle.

Optional Feature:
- Macro: RV32_RF_BYPASS_EN.
- Defined: for port i with c_rf_write && rd_addr==rs_addr[i] && rd_addr!=0 in RUN:
  - rs_dato[i]=rd_dati;
  - rs_busy[i]=0 unless a same-cycle reserve targets the same address;
  - resv_busy likewise sees the release.
- Undefined: no forwarding; the same-cycle write is visible next cycle, and rs_busy reflects the pre-edge scoreboard.

Decomposition:
- Shared package rv32_rf_pkg holds:
  - rf_state_e enum {RF_CLEAR, RF_RUN};
  - default constants XLEN_D=32, NREG_D=32, NUM_RD_D=2;
  - REG_ZERO='0.
- One sub-module rv32_rf_rdport: a single read mux with x0 masking and optional bypass, instantiated NUM_RD times by generate.
- Scoreboard and clear FSM stay in the top module.

Test Plan:
- Reset release with NREG=32 -> rf_ready rises exactly 31 cycles after rst falls; all 31 registers then read 0; rs_busy all 1 until ready.
- Write x5=0xDEADBEEF, read x5 the next cycle on port 1 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
- Same cycle: write x7=0xA5A5A5A5 while reading x7 -> old value without the macro, 0xA5A5A5A5 with RV32_RF_BYPASS_EN.
- Reserve x9 -> rs_busy=1 and resv_busy=1 next cycle; writeback x9=0x42 -> busy=0 next cycle.
- Simultaneous write and reserve on x9 -> rs_busy stays 1 and the data updates.
- Assert rst for 1 cycle at clr_ptr=10 and again in RUN with x3 reserved -> CLEAR restarts, ready after a further 31 cycles, x3 not busy and reading 0.
- NREG=16, NUM_RD=3 -> ready after 15 cycles; three independent ports return correct data.
